// File: rtl/sdram_log_sequencer.sv
// sdram_log_sequencer: buffers 16-bit log words and turns them into single-word
// SDRAM controller WRITE commands at a linearly incrementing address, and serves
// sequential read-back requests with READ commands. It owns the memory pointers.
//
// Ports:
//   i_clk_48mhz      system clock, all logic on the rising edge
//   i_reset_n        synchronous active-low reset
//   i_wr_data/valid  producer word and valid; o_wr_ready = buffer not full
//   i_rd_req         one-cycle pulse requesting the next stored word
//   o_rd_data/valid  read-back word and its one-cycle valid pulse
//   o_rd_empty       nothing stored to read back (rd_ptr == wr_ptr)
//   o_mem_full       memory exhausted (only when wrapping is disabled)
//   o_err            sticky controller-timeout flag
//   o_cmd_out        controller command: 0 idle, 1 read, 2 write
//   o_a_out_*        bank/row/col of the 24-bit linear address
//   o_d_out          write data to the controller
//   i_sdram_status   controller ready (1) / busy (0)
//   i_sdram_data     controller read data
module sdram_log_sequencer #(
    parameter int FIFO_AW = 3,
    parameter bit WRAP_EN = 1'b0,
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk_48mhz,
    input  logic        i_reset_n,
    input  logic [15:0] i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic        i_rd_req,
    output logic [15:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_empty,
    output logic        o_mem_full,
    output logic        o_err,
    output logic [1:0]  o_cmd_out,
    output logic [1:0]  o_a_out_bank,
    output logic [12:0] o_a_out_row,
    output logic [8:0]  o_a_out_col,
    output logic [15:0] o_d_out,
    input  logic        i_sdram_status,
    input  logic [15:0] i_sdram_data
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [FIFO_AW:0] HALF = (FIFO_AW + 1)'(DEPTH / 2);

    typedef enum logic [2:0] {IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD} state_t;

    state_t               r_state, w_next;
    logic [15:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_fifo_wp, r_fifo_rp;
    logic [FIFO_AW:0]     r_count;
    logic [23:0]          r_wr_ptr, r_rd_ptr, r_addr;
    logic [15:0]          r_dout, r_rd_data;
    logic [CW-1:0]        r_wait_cnt;
    logic                 r_rd_valid, r_err, r_mem_full, r_rd_pend, r_retry, r_ready_en;
    logic                 w_push, w_pop, w_fifo_empty, w_rd_empty, w_wr_ok, w_rd_ok;
    logic                 w_wr_first, w_waiting, w_done, w_timeout;
    logic [23:0]          w_wr_nxt;

    // Count never exceeds DEPTH, so its MSB alone marks full.
    assign o_wr_ready   = r_ready_en && !r_count[FIFO_AW];
    assign w_push       = i_wr_valid && o_wr_ready;
    assign w_fifo_empty = r_count == '0;
    assign w_rd_empty   = r_rd_ptr == r_wr_ptr;
    assign w_wr_nxt     = r_wr_ptr + 24'd1;
    // A timed-out write keeps its word in r_dout and is retried ahead of new work.
    assign w_wr_ok      = (r_retry || !w_fifo_empty) && !r_mem_full && i_sdram_status;
    assign w_rd_ok      = r_rd_pend && !w_rd_empty && i_sdram_status;
    assign w_wr_first   = w_wr_ok && (!w_rd_ok || r_retry || r_count >= HALF);
    assign w_waiting    = r_state == WAIT_WR || r_state == WAIT_RD;
    // The first WAIT cycle ignores STATUS: the controller may not have dropped it yet.
    assign w_done       = w_waiting && r_wait_cnt != '0 && i_sdram_status;
    assign w_timeout    = w_waiting && !w_done && r_wait_cnt == CW'(TIMEOUT);
    assign w_pop        = r_state == IDLE && w_wr_first && !r_retry;

    assign o_cmd_out = r_state == ISSUE_WR ? 2'd2 : r_state == ISSUE_RD ? 2'd1 : 2'd0;
    assign {o_a_out_bank, o_a_out_row, o_a_out_col} = r_addr;
    assign o_d_out    = r_dout;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_empty = w_rd_empty;
    assign o_mem_full = r_mem_full;
    assign o_err      = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:             w_next = w_wr_first ? ISSUE_WR : w_rd_ok ? ISSUE_RD : IDLE;
            ISSUE_WR:         w_next = WAIT_WR;
            ISSUE_RD:         w_next = WAIT_RD;
            WAIT_WR, WAIT_RD: w_next = (w_done || w_timeout) ? IDLE : r_state;
            default:          w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_48mhz) begin
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk_48mhz) begin
        if (w_push) r_mem[r_fifo_wp] <= i_wr_data;
    end

    always_ff @(posedge i_clk_48mhz) begin
        if (!i_reset_n) begin
            r_fifo_wp  <= '0;
            r_fifo_rp  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_rd_data  <= '0;
            r_wait_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_mem_full <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_retry    <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_rd_valid <= 1'b0;
            r_wait_cnt <= w_waiting ? r_wait_cnt + 1'b1 : '0;
            if (w_push) r_fifo_wp <= r_fifo_wp + 1'b1;
            if (w_pop) r_fifo_rp <= r_fifo_rp + 1'b1;
            r_count <= r_count + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
            if (i_rd_req && !w_rd_empty) r_rd_pend <= 1'b1;
            if (r_state == IDLE && w_next == ISSUE_WR) begin
                r_addr <= r_wr_ptr;
                if (!r_retry) r_dout <= r_mem[r_fifo_rp];
            end else if (r_state == IDLE && w_next == ISSUE_RD) begin
                r_addr <= r_rd_ptr;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
                if (r_state == WAIT_WR) r_retry <= 1'b1;
            end
            if (w_done && r_state == WAIT_WR) begin
                r_retry <= 1'b0;
                if (WRAP_EN || r_wr_ptr != '1) begin
                    r_wr_ptr <= w_wr_nxt;
                    // Catching up with the reader overwrites its oldest word.
                    if (w_wr_nxt == r_rd_ptr) r_rd_ptr <= r_rd_ptr + 24'd1;
                end else begin
                    r_mem_full <= 1'b1;
                end
            end
            if (w_done && r_state == WAIT_RD) begin
                r_rd_data  <= i_sdram_data;
                r_rd_valid <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + 24'd1;
                r_rd_pend  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sdram_log_sequencer.md
Name: sdram_log_sequencer

Overview:
- Command-side client of the SDRAM controller. Buffers 16-bit log words from upstream producers and issues single-word WRITE commands at a linearly incrementing address.
- Serves sequential read-back requests from the downlink path by issuing READ commands.
- Owns all memory traversal, i.e. the pointers and full/empty state. The controller only executes one command at a time.

Parameters:
- FIFO_AW, 3, log2 of write-buffer depth (depth 8).
- WRAP_EN, 0: 1 = write pointer wraps at end of memory; 0 = stop and assert MEM_FULL.
- TIMEOUT, 255, maximum cycles to wait for controller completion before flagging ERR.

Ports:
- CLK_48MHZ  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- WR_DATA  in  16  log word from producer.
- WR_VALID  in  1  producer word valid.
- WR_READY  out  1  buffer not full; word accepted when WR_VALID&WR_READY.
- RD_REQ  in  1  one-cycle pulse: fetch next stored word.
- RD_DATA  out  16  read-back word.
- RD_VALID  out  1  one-cycle pulse, RD_DATA valid.
- RD_EMPTY  out  1  rd_ptr == wr_ptr (nothing to read back).
- MEM_FULL  out  1  memory exhausted (WRAP_EN=0 only).
- ERR  out  1  sticky controller-timeout flag.
- CMD_OUT  out  2  to controller CMD_IN: 0 idle, 1 read, 2 write.
- A_OUT_BANK  out  2  to A_IN_BANK.
- A_OUT_ROW  out  13  to A_IN_ROW.
- A_OUT_COL  out  9  to A_IN_COL.
- D_OUT  out  16  to D_IN.
- SDRAM_STATUS  in  1  controller STATUS: 1 = idle/ready, 0 = busy or initialising.
- SDRAM_DATA  in  16  controller DATA_READ.

Behaviour:
- Reset (RESET_N=0 at a rising edge):
  - Outputs: CMD_OUT=0, address outputs 0, D_OUT=0, RD_DATA=0, RD_VALID=0, ERR=0, MEM_FULL=0.
  - Internal: wr_ptr=rd_ptr=0, FIFO emptied, FSM=IDLE.
  - WR_READY=0 during reset; it goes to 1 in the first cycle after reset.
  - Reset mid-command drops the command immediately. No completion is waited for.
- Linear address is 24 bits, {bank[23:22], row[21:9], col[8:0]}. Pointers are 24 bits and increment by 1.
- Write buffer:
  - Synchronous FIFO, 2^FIFO_AW entries. WR_READY = !fifo_full.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - A push attempted while full is impossible by handshake.
- Controller handshake:
  - A command is issued only in IDLE with SDRAM_STATUS=1.
  - CMD_OUT, address and D_OUT are driven for exactly one cycle (ISSUE state), then CMD_OUT returns to 0.
  - In WAIT, SDRAM_STATUS is ignored for the first cycle. Completion is the first later cycle with SDRAM_STATUS=1.
  - Only one command is outstanding at a time.
  - Post-reset controller initialisation is covered because IDLE requires SDRAM_STATUS=1.
- FSM states: IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD.
  - IDLE -> ISSUE_WR when the FIFO is non-empty, !MEM_FULL and SDRAM_STATUS=1. The FIFO head is popped into D_OUT and the address = wr_ptr.
  - IDLE -> ISSUE_RD when a read is pending, !RD_EMPTY and SDRAM_STATUS=1. Address = rd_ptr.
  - Both eligible: write wins if FIFO count >= half depth; otherwise read wins.
  - ISSUE_x -> WAIT_x after 1 cycle.
  - WAIT_WR -> IDLE on completion; wr_ptr++.
  - WAIT_RD -> IDLE on completion; RD_DATA <= SDRAM_DATA captured that cycle, RD_VALID=1 for 1 cycle, rd_ptr++.
- Read requests:
  - RD_REQ sets a single pending bit. Extra pulses while pending are ignored.
  - RD_REQ while RD_EMPTY=1 is dropped and no RD_VALID is produced.
- Wrap and full:
  - wr_ptr at 24'hFFFFFF completing a write with WRAP_EN=1: wraps to 0.
  - If the wrap makes wr_ptr == rd_ptr, rd_ptr is advanced by 1, discarding the oldest word.
  - With WRAP_EN=0: MEM_FULL=1 and remains set until reset. Further writes are never issued; the FIFO fills and WR_READY drops.
  - rd_ptr wraps naturally at 2^24.
- Timeout:
  - A cycle counter runs in WAIT_x. If it reaches TIMEOUT without completion: ERR=1 (sticky), FSM -> IDLE.
  - The pointer does not advance, so the same write is retried. A pending read stays pending.

Test Plan:
- Post-reset with SDRAM_STATUS held 0 for 100 cycles, then 1 -> CMD_OUT stays 0 until STATUS=1; first write is issued the cycle after.
- Push 0xA5A5, 0x1234; controller model busy 3 cycles per command -> CMD_OUT=2 for one cycle each.
  - Addresses {0,0,0} then col=1; D_OUT=0xA5A5, 0x1234.
  - wr_ptr=2, RD_EMPTY=0.
- After the above, RD_REQ; model returns 0xA5A5 -> CMD_OUT=1 at address 0; RD_VALID one cycle with RD_DATA=0xA5A5; rd_ptr=1.
- Fill the FIFO (8 words) with STATUS=0 -> WR_READY=0.
  - Issue RD_REQ, then release STATUS -> write issued first because count >= 4.
- Preload wr_ptr=24'hFFFFFF (force), WRAP_EN=0, then one write -> MEM_FULL=1 and no further CMD_OUT=2.
  - Same with WRAP_EN=1 -> wr_ptr=0.
- Controller never completes (STATUS=0 after issue) -> ERR=1 after TIMEOUT cycles; the same write is reissued once STATUS=1. Then assert RESET_N=0 mid-WAIT -> all outputs return to reset values next edge.
